wb_fair_responder: RTL

- Synthesizable, parametrised bus-environment model for the core's Wishbone data/instruction port.
- Sits between the core and a nondeterministic source, in formal and in simulation. Shapes the free `ack_req`/`err_req`/`dat_r_in` inputs into a legal, bounded-latency classic-Wishbone response.
- Tracks trap nesting from retirement info and flags when the allowed nesting depth is exceeded.
- Generalises the fixed 1..4-cycle fairness and single-level trap limits into parameters, and adds error responses and cycle aborts.

---
 rtl/wb_fair_responder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/wb_fair_responder.sv
// Wishbone bus-environment responder. It turns free ack/err/data inputs into a
// legal classic-Wishbone response with bounded latency (MIN_WAIT..MAX_WAIT
// wait cycles, then a single RESP cycle). It also tracks trap nesting from
// retirement information.
//
// state | meaning
// IDLE  | no transaction; a cyc&stb request is accepted here
// WAIT  | request accepted, counting wait cycles until a response is allowed/forced
// RESP  | bus_ack or bus_err is high for exactly this cycle
module wb_fair_responder #(
   parameter int ADDR_W   = 30,
   parameter int DATA_W   = 32,
   parameter int MIN_WAIT = 1,
   parameter int MAX_WAIT = 4,
   parameter bit ERR_EN   = 1'b0,
   parameter int NEST_MAX = 1,
   parameter int SEL_W    = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bus_cyc,
   input  logic              bus_stb,
   input  logic              bus_we,
   input  logic [ADDR_W-1:0] bus_adr,
   input  logic [SEL_W-1:0]  bus_sel,
   output logic              bus_ack,
   output logic              bus_err,
   output logic [DATA_W-1:0] bus_dat_r,
   input  logic              ack_req,
   input  logic              err_req,
   input  logic [DATA_W-1:0] dat_r_in,
   input  logic              retire,
   input  logic              trap,
   input  logic              mret,
   output logic              busy,
   output logic [7:0]        wait_cnt,
   output logic              abort,
   output logic              zero_sel,
   output logic [ADDR_W-1:0] last_adr,
   output logic [3:0]        trap_nest,
   output logic              nest_ovf
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [7:0] MIN_W8  = 8'(MIN_WAIT);
   localparam logic [7:0] MAX_W8  = 8'(MAX_WAIT);
   localparam logic [3:0] NEST_M4 = 4'(NEST_MAX);

   logic [1:0]        state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic              abort_q, abort_d;
   logic              zsel_q, zsel_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [3:0]        nest_q, nest_d;
   logic              ovf_q, ovf_d;

   // Bus handshake: accept, count wait cycles, respond or abort.
   always_comb begin
      logic take_err;
      take_err = 1'b0;
      state_d  = state_q;
      cnt_d    = cnt_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      dat_d    = dat_q;
      abort_d  = 1'b0;
      zsel_d   = zsel_q;
      adr_d    = adr_q;
      case (state_q)
         S_IDLE: begin
            if (bus_cyc && bus_stb) begin
               state_d = S_WAIT;
               cnt_d   = 8'd1;
               adr_d   = bus_adr;
               zsel_d  = zsel_q | (bus_sel == '0);
            end
         end
         S_WAIT: begin
            if (!bus_cyc) begin
               state_d = S_IDLE;
               cnt_d   = 8'd0;
               abort_d = 1'b1;
            end else if ((cnt_q >= MIN_W8) && (ack_req || (cnt_q == MAX_W8))) begin
               // Reaching MAX_WAIT forces the response, so the count never
               // increments past it.
               state_d  = S_RESP;
               take_err = ERR_EN && err_req;
               err_d    = take_err;
               ack_d    = !take_err;
               if (!bus_we && !take_err) begin
                  dat_d = dat_r_in;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Trap nesting depth, saturating at NEST_MAX with a sticky overflow flag.
   always_comb begin
      nest_d = nest_q;
      ovf_d  = ovf_q;
      if (retire) begin
         if (trap) begin
            if (nest_q >= NEST_M4) begin
               ovf_d  = 1'b1;
               nest_d = NEST_M4;
            end else begin
               nest_d = nest_q + 4'd1;
            end
         end else if (mret && (nest_q != 4'd0)) begin
            nest_d = nest_q - 4'd1;
         end
      end
   end

   // State registers; reset drops any in-flight response immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
         abort_q <= 1'b0;
         zsel_q  <= 1'b0;
         adr_q   <= '0;
         nest_q  <= 4'd0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
         abort_q <= abort_d;
         zsel_q  <= zsel_d;
         adr_q   <= adr_d;
         nest_q  <= nest_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus_ack   = ack_q;
   assign bus_err   = err_q;
   assign bus_dat_r = dat_q;
   assign busy      = (state_q != S_IDLE);
   assign wait_cnt  = cnt_q;
   assign abort     = abort_q;
   assign zero_sel  = zsel_q;
   assign last_adr  = adr_q;
   assign trap_nest = nest_q;
   assign nest_ovf  = ovf_q;

endmodule
